seven_seg_digit_driver: RTL and testbench
=========================================

SEVEN_SEG_DIGIT_DRIVER -- requirements
Module: seven_seg_digit_driver

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1, SHALL select segment and dp polarity: 1 means 0 = lit, 0 means 1 = lit.
REQ-002 div_clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge; it is the same net that clocks the anode scanner.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 anode_in  input  4  SHALL be the scanner's one-hot-low digit select, synchronous to div_clock.
REQ-005 value  input  16  SHALL be the display word, four hex nibbles; digit k = value[4k+3:4k].
REQ-006 load  input  1  SHALL be a single-cycle request to capture value.
REQ-007 dp_mask  input  4  SHALL hold per-digit decimal-point enables (bit k = digit k), sampled live, active-high.
REQ-008 lzb  input  1  SHALL enable leading-zero blanking when high, sampled live.
REQ-009 anode  output  4  SHALL be the registered, one-hot-low anode drive to the board.
REQ-010 seg  output  7  SHALL be the registered segment drive {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  SHALL be the registered decimal-point drive.
REQ-012 busy  output  1  SHALL be high while a loaded word awaits commit.

Function
REQ-013 The block SHALL hold a 16-bit staging register, a 16-bit display register and a pending flag.
REQ-014 When load=1, the block SHALL write value into staging and set pending on that edge.
REQ-015 Commit: on an edge where pending=1 and anode_in=4'b1110, the block SHALL copy staging into the display register and clear pending.
REQ-016 When load=1 and anode_in=4'b1110 on the same edge, the block SHALL write value directly into both staging and display, leaving pending=0.
REQ-017 When load=1 and a commit would otherwise occur on a different pattern, load SHALL win: staging is overwritten, pending stays 1, and the display register is unchanged.
REQ-018 busy SHALL equal pending.
REQ-019 Digit select: anode_in 1110/1101/1011/0111 SHALL select display digit 0/1/2/3 respectively.
REQ-020 Decode SHALL be standard hex: 0-9, A, b, C, d, E, F. For example, 0 lights a-f, 1 lights b,c, and 8 lights all segments.
REQ-021 Leading-zero blanking: with lzb=1, digit k (k=1..3) SHALL be blanked when display nibbles k..3 are all zero. Digit 0 SHALL never be blanked.
REQ-022 A blanked digit SHALL drive no lit segments; dp SHALL still follow dp_mask.
REQ-023 Any anode_in other than the four legal patterns (including 1111 and multi-low) SHALL produce anode=1111, all segments unlit, and dp unlit.
REQ-024 Latency: anode, seg and dp SHALL reflect the anode_in, display register, dp_mask and lzb sampled on the previous edge. This is exactly 1 cycle.
REQ-025 For a legal pattern, anode SHALL equal the registered anode_in.
REQ-026 A commit edge SHALL NOT alter the digit-0 output produced on that same edge; the new word SHALL first appear one cycle after the commit edge.

Reset
REQ-027 While reset=1: anode=1111, seg all unlit (7'h7F when SEG_ACTIVE_LOW=1), dp unlit, staging=0, display=0, pending=0, busy=0.
REQ-028 Reset asserted mid-load or mid-commit SHALL discard the pending word; after release, no commit SHALL occur until a new load.
REQ-029 On the first edge after release, the block SHALL decode the incoming anode_in against display=0.

Verification
REQ-030 Reset, then rotate anode_in 1110->1101->1011->0111 with lzb=0 -> seg shows "0" (7'b1000000) on each digit one cycle later, anode tracks, busy=0.
REQ-031 load value=16'h12AF while anode_in=1011 -> busy=1 and the display is unchanged until anode_in=1110. Commit on that edge. The next cycle digit0 shows F (7'b0001110), and digits 1/2/3 then show A/2/1.
REQ-032 value=16'h0005, lzb=1, dp_mask=4'b0100, full rotation -> digit0 shows 5; digits 1 and 3 are dark; digit 2 is dark with dp lit.
REQ-033 load with anode_in=1110 on the same edge, value=16'h8888 -> busy stays 0 and the display register updates that edge. Also: load 16'h1111, then load 16'h2222 before the frame boundary -> only 2222 is ever displayed.
REQ-034 anode_in=4'b1100 and then 4'b1111 -> one cycle later anode=1111, seg all unlit, dp unlit, irrespective of display contents.
REQ-035 Assert reset asynchronously while busy=1 mid-frame -> outputs go to reset values immediately. After release, rotate a full frame -> display stays 0000.

Source files
------------

// File: rtl/seven_seg_digit_driver_if.sv
// Bundles the digit driver's scanner/host inputs and board-facing outputs.
//   anode_in : one-hot-low digit select from the anode scanner
//   value    : 16-bit display word, four hex nibbles
//   load     : single-cycle request to capture value
//   dp_mask  : per-digit decimal-point enables (active-high)
//   lzb      : leading-zero blanking enable
//   anode    : registered one-hot-low anode drive
//   seg      : registered segment drive {g,f,e,d,c,b,a}
//   dp       : registered decimal-point drive
//   busy     : a loaded word is waiting for the frame boundary
interface seven_seg_digit_driver_if;
  logic [3:0]  anode_in;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        lzb;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  modport master (
    output anode_in, value, load, dp_mask, lzb,
    input  anode, seg, dp, busy
  );

  modport slave (
    input  anode_in, value, load, dp_mask, lzb,
    output anode, seg, dp, busy
  );
endinterface

// File: rtl/seven_seg_digit_driver.sv
// Seven-segment digit driver: stages a 16-bit word, commits it to the display
// register at the frame boundary (anode_in == 1110), and decodes the digit
// picked by the scanner into registered anode/seg/dp drives.
//   div_clock : scan clock, all state on rising edge
//   reset     : asynchronous active-high reset
//   bus       : slave side of seven_seg_digit_driver_if
module seven_seg_digit_driver #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                      div_clock,
  input logic                      reset,
  seven_seg_digit_driver_if.slave  bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic             DP_ON   = ~SEG_ACTIVE_LOW;
  localparam logic [DIG_W-1:0] ANODE_OFF   = 4'b1111;
  localparam logic [DIG_W-1:0] FRAME_START = 4'b1110;

  logic [WORD_W-1:0] staging_q, staging_d;
  logic [WORD_W-1:0] display_q, display_d;
  logic              pending_q, pending_d;
  logic [DIG_W-1:0]  anode_q, anode_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              legal_c;
  logic [1:0]        digit_sel_c;
  logic [3:0]        nibble_c;
  logic              blank_c;
  logic              zero_from1_c, zero_from2_c, zero_from3_c;
  logic [SEG_W-1:0]  hex_seg_c;

  // Active-high hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] n);
    logic [SEG_W-1:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Staging / commit: a load always wins; a load on the frame-start edge
  // bypasses staging and lands in the display register directly.
  always_comb begin
    staging_d = staging_q;
    display_d = display_q;
    pending_d = pending_q;
    if (bus.load) begin
      staging_d = bus.value;
      if (bus.anode_in == FRAME_START) begin
        display_d = bus.value;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (pending_q && (bus.anode_in == FRAME_START)) begin
      display_d = staging_q;
      pending_d = 1'b0;
    end
  end

  // Digit select from the one-hot-low scan pattern; anything else is dark.
  always_comb begin
    legal_c     = 1'b1;
    digit_sel_c = 2'd0;
    case (bus.anode_in)
      4'b1110: digit_sel_c = 2'd0;
      4'b1101: digit_sel_c = 2'd1;
      4'b1011: digit_sel_c = 2'd2;
      4'b0111: digit_sel_c = 2'd3;
      default: legal_c     = 1'b0;
    endcase
  end

  // Leading-zero detection over the current display register; a commit on
  // this edge only becomes visible on the following edge.
  always_comb begin
    zero_from3_c = (display_q[15:12] == 4'h0);
    zero_from2_c = zero_from3_c && (display_q[11:8] == 4'h0);
    zero_from1_c = zero_from2_c && (display_q[7:4] == 4'h0);
    nibble_c     = display_q[3:0];
    blank_c      = 1'b0;
    case (digit_sel_c)
      2'd0: nibble_c = display_q[3:0];
      2'd1: begin nibble_c = display_q[7:4];   blank_c = bus.lzb && zero_from1_c; end
      2'd2: begin nibble_c = display_q[11:8];  blank_c = bus.lzb && zero_from2_c; end
      2'd3: begin nibble_c = display_q[15:12]; blank_c = bus.lzb && zero_from3_c; end
      default: nibble_c = display_q[3:0];
    endcase
    hex_seg_c = hex_glyph(nibble_c);
  end

  // Output drive with polarity applied.
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    if (legal_c) begin
      anode_d = bus.anode_in;
      if (!blank_c) begin
        seg_d = SEG_ACTIVE_LOW ? SEG_W'(~hex_seg_c) : hex_seg_c;
      end
      if (bus.dp_mask[digit_sel_c]) begin
        dp_d = DP_ON;
      end
    end
  end

  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      staging_q <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      anode_q   <= ANODE_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
    end else begin
      staging_q <= staging_d;
      display_q <= display_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.anode = anode_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.busy  = pending_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Scoreboard bench for seven_seg_digit_driver: a driver applies one input set
// per cycle and queues the expected registered outputs from a word-level
// model; a monitor pops and compares after each rising edge.
module tb_seven_seg_digit_driver;

  localparam bit ACTIVE_LOW = 1'b1;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    string      tag;
  } exp_t;

  logic div_clock = 1'b0;
  logic reset     = 1'b1;
  int   n_tests   = 0;
  int   n_fail    = 0;
  exp_t exp_q[$];
  string cur_tag = "init";

  seven_seg_digit_driver_if bus ();

  seven_seg_digit_driver #(.SEG_ACTIVE_LOW(ACTIVE_LOW)) dut (
    .div_clock (div_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 div_clock = ~div_clock;

  // Reference model state.
  logic [15:0] m_stage = '0;
  logic [15:0] m_disp  = '0;
  logic        m_pend  = 1'b0;

  // Lit-segment sets for hex digits, {g,f,e,d,c,b,a}, active-high.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] drive(input logic [6:0] lit);
    return ACTIVE_LOW ? 7'(~lit) : lit;
  endfunction

  function automatic logic drive_dp(input logic lit);
    return ACTIVE_LOW ? ~lit : lit;
  endfunction

  task automatic model_reset();
    m_stage = '0;
    m_disp  = '0;
    m_pend  = 1'b0;
  endtask

  // Apply one cycle of stimulus and queue what the following edge must show.
  task automatic step(input logic [3:0] a, input logic [15:0] v, input logic ld,
                      input logic [3:0] dm, input logic l);
    exp_t e;
    int   k;
    int   upper;
    @(negedge div_clock);
    bus.anode_in = a;
    bus.value    = v;
    bus.load     = ld;
    bus.dp_mask  = dm;
    bus.lzb      = l;
    k = -1;
    for (int i = 0; i < 4; i++) begin
      if (a == 4'(~(4'b0001 << i))) k = i;
    end
    if (k < 0) begin
      e.anode = 4'b1111;
      e.seg   = drive(7'h00);
      e.dp    = drive_dp(1'b0);
    end else begin
      upper   = int'(m_disp) >> (4 * k);
      e.anode = a;
      if (l && k > 0 && upper == 0) e.seg = drive(7'h00);
      else                          e.seg = drive(glyph[upper % 16]);
      e.dp    = drive_dp(dm[k]);
    end
    if (ld) begin
      m_stage = v;
      if (k == 0) begin m_disp = v; m_pend = 1'b0; end
      else        m_pend = 1'b1;
    end else if (m_pend && k == 0) begin
      m_disp = m_stage;
      m_pend = 1'b0;
    end
    e.busy = m_pend;
    e.tag  = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic rotate(input logic [3:0] dm, input logic l);
    for (int i = 0; i < 4; i++) step(4'(~(4'b0001 << i)), 16'h0000, 1'b0, dm, l);
  endtask

  task automatic check_now(input string name, input logic [3:0] an, input logic [6:0] sg,
                           input logic d, input logic b);
    n_tests++;
    if (bus.anode !== an || bus.seg !== sg || bus.dp !== d || bus.busy !== b) begin
      n_fail++;
      $display("FAIL %s: got anode=%b seg=%b dp=%b busy=%b, want anode=%b seg=%b dp=%b busy=%b",
               name, bus.anode, bus.seg, bus.dp, bus.busy, an, sg, d, b);
    end
  endtask

  // Monitor: every driven cycle yields one registered output set.
  always @(posedge div_clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.anode !== e.anode || bus.seg !== e.seg || bus.dp !== e.dp || bus.busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s: got anode=%b seg=%b dp=%b busy=%b, want anode=%b seg=%b dp=%b busy=%b",
                 e.tag, bus.anode, bus.seg, bus.dp, bus.busy, e.anode, e.seg, e.dp, e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    bus.anode_in = 4'b1111;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.dp_mask  = '0;
    bus.lzb      = 1'b0;
    repeat (2) @(posedge div_clock);
    #1;
    check_now("reset_state", 4'b1111, 7'h7F, 1'b1, 1'b0);
    @(negedge div_clock);
    reset = 1'b0;
    model_reset();

    cur_tag = "zero_rotation";
    rotate(4'b0000, 1'b0);

    cur_tag = "load_12AF_commit";
    step(4'b1011, 16'h12AF, 1'b1, 4'b0000, 1'b0);
    step(4'b0111, 16'h0000, 1'b0, 4'b0000, 1'b0);
    rotate(4'b0000, 1'b0);
    rotate(4'b0000, 1'b0);

    cur_tag = "lzb_0005";
    step(4'b1101, 16'h0005, 1'b1, 4'b0100, 1'b1);
    rotate(4'b0100, 1'b1);
    rotate(4'b0100, 1'b1);

    cur_tag = "direct_8888";
    step(4'b1110, 16'h8888, 1'b1, 4'b0000, 1'b0);
    rotate(4'b0000, 1'b0);

    cur_tag = "reload_2222";
    step(4'b1101, 16'h1111, 1'b1, 4'b0000, 1'b0);
    step(4'b1011, 16'h2222, 1'b1, 4'b0000, 1'b0);
    step(4'b0111, 16'h0000, 1'b0, 4'b0000, 1'b0);
    rotate(4'b0000, 1'b0);
    rotate(4'b0000, 1'b0);

    cur_tag = "illegal_anode";
    step(4'b1100, 16'h0000, 1'b0, 4'b1111, 1'b0);
    step(4'b1111, 16'h0000, 1'b0, 4'b1111, 1'b0);
    step(4'b0000, 16'h0000, 1'b0, 4'b1111, 1'b1);

    cur_tag = "random";
    for (int n = 0; n < 400; n++) begin
      a = 4'(~(4'b0001 << (n % 4)));
      if ($urandom_range(0, 9) == 0) a = 4'($urandom_range(0, 15));
      step(a, 16'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    cur_tag = "pre_reset_load";
    step(4'b1101, 16'hABCD, 1'b1, 4'b0000, 1'b0);
    step(4'b1011, 16'h0000, 1'b0, 4'b0000, 1'b0);
    @(posedge div_clock);
    #3;
    reset = 1'b1;
    #1;
    check_now("async_reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
    @(negedge div_clock);
    bus.anode_in = 4'b1110;
    bus.load     = 1'b0;
    @(posedge div_clock);
    #1;
    check_now("reset_hold", 4'b1111, 7'h7F, 1'b1, 1'b0);
    @(negedge div_clock);
    bus.anode_in = 4'b1111;
    reset = 1'b0;
    model_reset();

    cur_tag = "post_reset_frame";
    rotate(4'b0000, 1'b0);
    rotate(4'b0000, 1'b0);

    @(posedge div_clock);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
